// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit.
//
// Owns the architectural PC. Fetches one word at a time from instruction
// memory over a req/ack handshake. Presents each fetched word with its PC to
// decode over a valid/ready handshake. At each hand-off it commits npc. If npc
// is misaligned or outside [PC_LO, PC_HI], it stops fetching and latches a
// sticky fault.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   reset        asynchronous active-low reset
//   imem_req     fetch request to instruction memory
//   imem_addr    fetch word address (always equal to pc)
//   imem_ack     memory acknowledge; imem_rdata is valid this cycle
//   imem_rdata   instruction word from memory
//   instr        fetched instruction presented to decode
//   pc           PC of instr; also feeds the next-PC logic
//   instr_valid  instr/pc are valid for decode
//   instr_ready  decode accepts instr this cycle
//   npc          next PC, sampled only at the hand-off
//   fault        sticky illegal-next-PC flag
//   fault_pc     npc value that caused the fault
//   instr_count  completed hand-offs, wraps modulo 2^32
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_LO    = 32'h0000_3000,
  parameter logic [31:0] PC_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [31:0] npc,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDeliver,
    StFault
  } state_e;

  state_e      state_q;
  logic        req_q;
  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        fault_q;
  logic [31:0] fault_pc_q;
  logic [31:0] count_q;

  // Legality check on npc: word aligned and inside the fetch window.
  logic npc_legal;
  always_comb begin
    npc_legal = (npc[1:0] == 2'b00) && (npc >= PC_LO) && (npc <= PC_HI);
  end

  // Single FSM register block. Every output is a flop, so there is no
  // combinational path from any input to any output. Because req_q and
  // valid_q are cleared by the asynchronous reset, an outstanding fetch or
  // hand-off is withdrawn immediately when reset is asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'h0;
      count_q    <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // The request is raised together with the move to FETCH.
          state_q <= StFetch;
          req_q   <= 1'b1;
        end

        StFetch: begin
          // Hold req and addr until the memory responds.
          if (imem_ack) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= StDeliver;
          end
        end

        StDeliver: begin
          // valid_q is always set here. Until decode accepts, nothing changes,
          // and imem_ack and npc are ignored.
          if (instr_ready) begin
            valid_q <= 1'b0;
            count_q <= count_q + 32'd1;
            if (npc_legal) begin
              pc_q    <= npc;
              req_q   <= 1'b1;
              state_q <= StFetch;
            end else begin
              fault_q    <= 1'b1;
              fault_pc_q <= npc;
              state_q    <= StFault;
            end
          end
        end

        StFault: begin
          // Terminal until reset. All state is frozen.
          state_q <= StFault;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fault       = fault_q;
  assign fault_pc    = fault_pc_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] npc;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] instr_count;

  // Stand-in next-PC logic: sequential by default, or a forced target.
  logic        npc_sel = 1'b0;
  logic [31:0] npc_force = 32'h0;
  assign npc = npc_sel ? npc_force : pc + 32'd4;

  int n_vec = 0;
  int n_err = 0;

  ifu_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .pc          (pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .npc         (npc),
    .fault       (fault),
    .fault_pc    (fault_pc),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".req"}, {31'h0, imem_req}, 32'd0);
    check({tag, ".valid"}, {31'h0, instr_valid}, 32'd0);
    check({tag, ".pc"}, pc, 32'h3000);
    check({tag, ".fault"}, {31'h0, fault}, 32'd0);
    check({tag, ".fault_pc"}, fault_pc, 32'h0);
    check({tag, ".count"}, instr_count, 32'd0);
  endtask

  initial begin
    // Reset values
    tick();
    check_reset_state("rst");
    check("rst.instr", instr, 32'h0);
    check("rst.addr", imem_addr, 32'h3000);

    // Zero-wait memory with decode always ready: sequential fetch
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1111_0000;
    tick();
    check("seq0.req", {31'h0, imem_req}, 32'd1);
    check("seq0.addr", imem_addr, 32'h3000);
    check("seq0.valid", {31'h0, instr_valid}, 32'd0);
    tick();
    check("seq0.dvalid", {31'h0, instr_valid}, 32'd1);
    check("seq0.instr", instr, 32'h1111_0000);
    check("seq0.dreq", {31'h0, imem_req}, 32'd0);
    imem_rdata = 32'h2222_0004;
    tick();
    check("seq1.addr", imem_addr, 32'h3004);
    check("seq1.count", instr_count, 32'd1);
    check("seq1.valid", {31'h0, instr_valid}, 32'd0);
    tick();
    check("seq1.instr", instr, 32'h2222_0004);
    check("seq1.dvalid", {31'h0, instr_valid}, 32'd1);
    imem_rdata = 32'h3333_0008;
    tick();
    check("seq2.addr", imem_addr, 32'h3008);
    check("seq2.count", instr_count, 32'd2);
    tick();
    check("seq2.instr", instr, 32'h3333_0008);
    tick();
    check("seq3.addr", imem_addr, 32'h300C);
    check("seq3.count", instr_count, 32'd3);
    check("seq3.req", {31'h0, imem_req}, 32'd1);

    // Memory acks three cycles after the request
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait.req", {31'h0, imem_req}, 32'd1);
      check("wait.addr", imem_addr, 32'h300C);
      check("wait.valid", {31'h0, instr_valid}, 32'd0);
      check("wait.instr", instr, 32'h3333_0008);
    end
    imem_ack = 1'b1; imem_rdata = 32'hC0DE_0003;
    tick();
    check("wait.instr_cap", instr, 32'hC0DE_0003);
    check("wait.valid_cap", {31'h0, instr_valid}, 32'd1);
    check("wait.req_drop", {31'h0, imem_req}, 32'd0);

    // Decode stall of 5 cycles, with stray acks and a changing npc
    instr_ready = 1'b0; imem_rdata = 32'hBAD0_BAD0; npc_sel = 1'b1; npc_force = 32'h5000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall.valid", {31'h0, instr_valid}, 32'd1);
      check("stall.instr", instr, 32'hC0DE_0003);
      check("stall.pc", pc, 32'h300C);
      check("stall.req", {31'h0, imem_req}, 32'd0);
      check("stall.count", instr_count, 32'd3);
      npc_force = npc_force + 32'h4;
    end

    // Jump to 0x4000 at the hand-off, then sequential
    instr_ready = 1'b1; npc_force = 32'h4000; imem_rdata = 32'h4444_4000;
    tick();
    check("jmp.addr", imem_addr, 32'h4000);
    check("jmp.count", instr_count, 32'd4);
    check("jmp.instr_hold", instr, 32'hC0DE_0003);
    npc_sel = 1'b0;
    tick();
    check("jmp.instr", instr, 32'h4444_4000);
    check("jmp.pc", pc, 32'h4000);
    imem_rdata = 32'h5555_4004;
    tick();
    check("jmp.seq_addr", imem_addr, 32'h4004);
    check("jmp.seq_count", instr_count, 32'd5);
    tick();
    check("jmp.seq_instr", instr, 32'h5555_4004);

    // Misaligned npc causes a fault
    npc_sel = 1'b1; npc_force = 32'h3002;
    tick();
    check("mis.fault", {31'h0, fault}, 32'd1);
    check("mis.fault_pc", fault_pc, 32'h3002);
    check("mis.count", instr_count, 32'd6);
    check("mis.pc", pc, 32'h4004);
    check("mis.valid", {31'h0, instr_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mis.req_off", {31'h0, imem_req}, 32'd0);
      check("mis.sticky", {31'h0, fault}, 32'd1);
      check("mis.count_frz", instr_count, 32'd6);
    end

    // Reset pulse clears the fault
    reset = 1'b0;
    #1;
    check_reset_state("rst2");
    #1;
    reset = 1'b1; npc_force = 32'h6FFC;

    // Upper-bound legal npc, then out-of-range npc
    tick();
    check("hi.req", {31'h0, imem_req}, 32'd1);
    check("hi.addr0", imem_addr, 32'h3000);
    tick();
    check("hi.valid", {31'h0, instr_valid}, 32'd1);
    tick();
    check("hi.addr", imem_addr, 32'h6FFC);
    check("hi.count", instr_count, 32'd1);
    check("hi.fault", {31'h0, fault}, 32'd0);
    npc_force = 32'h7000;
    tick();
    tick();
    check("rng.fault", {31'h0, fault}, 32'd1);
    check("rng.fault_pc", fault_pc, 32'h7000);
    check("rng.count", instr_count, 32'd2);
    check("rng.pc", pc, 32'h6FFC);
    tick();
    check("rng.req_off", {31'h0, imem_req}, 32'd0);

    reset = 1'b0;
    #1;
    check_reset_state("rst3");
    #1;
    reset = 1'b1; npc_sel = 1'b0; imem_ack = 1'b0;

    // Reset mid-FETCH with the ack still pending
    tick();
    check("rf.req", {31'h0, imem_req}, 32'd1);
    tick();
    check("rf.req_hold", {31'h0, imem_req}, 32'd1);
    reset = 1'b0;
    #1;
    check("rf.req_async", {31'h0, imem_req}, 32'd0);
    check("rf.valid_async", {31'h0, instr_valid}, 32'd0);
    #1;
    reset = 1'b1;
    tick();
    check("rf.restart_addr", imem_addr, 32'h3000);
    check("rf.restart_req", {31'h0, imem_req}, 32'd1);
    check("rf.restart_count", instr_count, 32'd0);

    // Reset mid-DELIVER
    imem_ack = 1'b1; imem_rdata = 32'h7777_0000;
    tick();
    check("rd.valid", {31'h0, instr_valid}, 32'd1);
    instr_ready = 1'b0;
    reset = 1'b0;
    #1;
    check("rd.valid_async", {31'h0, instr_valid}, 32'd0);
    check("rd.instr_async", instr, 32'h0);
    #1;
    reset = 1'b1; instr_ready = 1'b1;
    tick();
    check("rd.restart_addr", imem_addr, 32'h3000);
    check("rd.restart_req", {31'h0, imem_req}, 32'd1);
    check("rd.restart_count", instr_count, 32'd0);
    check("rd.restart_fault", {31'h0, fault}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit that owns the architectural PC register and consumes the next-PC value produced by the next-PC logic. It issues word fetches to instruction memory over a request/acknowledge handshake and presents each fetched instruction with its PC to decode over a valid/ready handshake. On each instruction hand-off it commits the next-PC value. It also checks that value for alignment and range, and halts fetch on a fault.

## Interface

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded at reset.
- PC_LO, 32'h0000_3000, lowest legal fetch address (inclusive).
- PC_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  word address of the fetch; always equals pc.
- imem_ack  in  1  memory acknowledges; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word returned by memory.
- instr  out  32  fetched instruction presented to decode.
- pc  out  32  PC of instr, and input to next-PC logic.
- instr_valid  out  1  instr/pc are valid for decode.
- instr_ready  in  1  decode accepts instr this cycle.
- npc  in  32  next PC from next-PC logic; combinational from pc/instr; sampled only at hand-off.
- fault  out  1  sticky; illegal next PC detected, fetch stopped.
- fault_pc  out  32  offending npc value captured at the fault.
- instr_count  out  32  number of completed hand-offs; wraps modulo 2^32.

## Operation

- States: IDLE, FETCH, DELIVER, FAULT.
- Reset (reset=0, asynchronous):
  - state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0.
  - fault=0, fault_pc=0, instr_count=0.
- IDLE: unconditionally moves to FETCH on the first rising edge after reset deasserts.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack.
  - On imem_ack=1: instr<=imem_rdata, instr_valid<=1, go to DELIVER.
- DELIVER:
  - imem_req=0. instr, pc and instr_valid are held stable while instr_ready=0.
  - On instr_valid && instr_ready: this is the hand-off.
    - instr_valid<=0 and instr_count<=instr_count+1.
    - npc is evaluated for legality.
  - npc is legal when npc[1:0]==2'b00 and PC_LO<=npc<=PC_HI, unsigned compare.
  - Legal npc: pc<=npc, go to FETCH.
  - Illegal npc: pc unchanged, fault<=1, fault_pc<=npc, go to FAULT.
- FAULT:
  - Terminal until reset. imem_req=0, instr_valid=0.
  - fault stays 1. pc and instr_count are frozen.
- imem_ack is ignored whenever imem_req=0 (IDLE, DELIVER, FAULT).
- imem_rdata is captured only on acknowledged FETCH cycles.
- instr_ready is ignored when instr_valid=0.
- npc is not sampled outside the hand-off cycle.
- instr_count wraps from 32'hFFFF_FFFF to 0 without side effects.
- The hand-off that triggers a fault is still counted.

## Timing

- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- imem_req rises in the first cycle after the first post-reset edge. IDLE lasts exactly one cycle.
- A zero-wait memory acknowledges in the same cycle as imem_req. With that memory and decode always ready, the steady state is 2 cycles per instruction:
  - FETCH (req+ack) followed by DELIVER (valid+ready).
  - instr_valid is high every other cycle.
- Memory wait of N cycles adds N cycles of FETCH, with imem_req held high throughout.
- A decode stall of M cycles adds M cycles of DELIVER.
- The new pc is visible the cycle after hand-off, together with the next imem_req.
- Reset asserted mid-FETCH or mid-DELIVER drops imem_req and instr_valid immediately (asynchronous). Any outstanding memory transaction is abandoned; memory must tolerate the withdrawn request.

## Test plan

- Reset, zero-wait memory, decode always ready, npc=pc+4:
  - imem_addr sequence is 0x3000, 0x3004, 0x3008.
  - instr_valid toggles each cycle.
  - instr_count=3 after three hand-offs.
- Memory acknowledges 3 cycles after req:
  - imem_req is held high 4 cycles with imem_addr stable.
  - instr is captured only on the ack cycle.
  - Acks injected while imem_req=0 change nothing.
- Decode holds instr_ready=0 for 5 cycles:
  - instr, pc and instr_valid are stable throughout.
  - No new imem_req is issued.
  - npc changes during the stall are ignored.
- Jump with npc=0x0000_4000 at hand-off: the next imem_addr is 0x4000, then sequential.
- npc=0x0000_3002, and separately npc=0x0000_7000:
  - fault=1 and fault_pc is the offending value.
  - imem_req stays 0 forever after; instr_count includes the faulting hand-off.
  - Pulse reset: pc=0x3000 and fault=0.
- Assert reset mid-FETCH with ack pending:
  - imem_req and instr_valid fall without a clock edge.
  - After release, fetch restarts at 0x3000 and instr_count=0.
